cache_c1_port: RTL
==================

# cache_c1_port

Bus-side front end of the L1 cache: the C1 slave port that sits directly downstream of the CPU on the shared tri-state C1 bus. It decodes two-cycle CPU transactions (command plus tag/set, then offset), collects write data, issues exactly one request to the cache core over a valid/ready handshake, and then drives the C1 response back onto the bus. Only one transaction is outstanding at a time.

## Interface
- MEM_ADDR_SIZE, 19: full byte address width.
- BUS_SIZE, 16: C1 data bus width.
- CACHE_OFFSET_SIZE, 4: line offset width; the bus carries MEM_ADDR_SIZE-CACHE_OFFSET_SIZE address bits.

Ports:
- clk  in  1  — the block's one clock; all sampling and driving on posedge.
- rst_n  in  1  — asynchronous, active-low reset.
- address  in  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  — tag/set in cycle A1; offset in the LSBs in cycle A2.
- data  inout  BUS_SIZE  — write data in; read data out.
- command  inout  3  — C1 command in; C1_WRITE32_RESP (7) out.
- req_valid  out  1  — request to the core is valid.
- req_ready  in  1  — core accepts the request.
- req_cmd  out  3  — captured C1 command.
- req_addr  out  MEM_ADDR_SIZE  — {tag_set, offset}.
- req_wdata  out  2*BUS_SIZE  — {A2 data, A1 data}.
- resp_valid  in  1  — core result is ready (one-cycle pulse).
- resp_rdata  in  2*BUS_SIZE  — read result.

## Operation
- Commands: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32_RESP=7. In IDLE, any sampled value other than 1–6 (including X/Z and 7) is ignored.
- States: IDLE → ADDR2 → TURN_IN → REQ → WAIT → RESP1 → [RESP2 only for READ32] → TURN_OUT → IDLE.
- IDLE: on a valid command, capture the command, the tag_set from address, and data as wdata_lo. Go to ADDR2.
- ADDR2: capture address[CACHE_OFFSET_SIZE-1:0] as the offset.
  - For WRITE32, capture data as wdata_hi.
  - For WRITE8/16, wdata_hi=0.
  - WRITE8 also zeroes wdata_lo[15:8].
- TURN_IN: one dead cycle while the CPU releases command.
- REQ: req_valid=1, with req_* stable, until the cycle in which req_ready=1. That cycle is the handshake; go to WAIT.
- WAIT: capture resp_rdata on resp_valid. A resp_valid in the handshake cycle itself is ignored.
- RESP1: drive command=7.
  - Reads drive data=rdata[15:0]; READ8 forces data[15:8]=0.
  - Writes and INV_LINE leave data undriven (z).
- RESP2 (READ32 only): drive command=7 and data=rdata[31:16].
- TURN_OUT: release both command and data; ignore the bus.
- Bus commands arriving in any state other than IDLE are ignored.
- Driver enables come only from registered state. There is no combinational path from bus inputs to bus outputs.

## Timing
- Reset values:
  - command=z and data=z (enables 0).
  - req_valid=0; req_cmd=0; req_addr=0; req_wdata=0.
  - state=IDLE.
- Reset asserted mid-transaction releases the bus immediately (asynchronously) and drops req_valid. Any later resp_valid is ignored.
- Latency, with A1 sampled at posedge T0:
  - req_valid rises after posedge T2 (entry into REQ).
  - With req_ready=1 at once and resp_valid one cycle after the handshake, the response drives from posedge T5.
  - Minimum A1-to-response latency is 5 cycles.
- Earliest next A1 is sampled in the cycle after TURN_OUT.
- req_ready held high outside REQ has no effect.

## Configuration
- Macro: CACHE_C1_PORT_INV_EN.
  - Defined: INV_LINE is forwarded to the core like any other request.
  - Undefined: INV_LINE skips REQ/WAIT and goes TURN_IN → RESP1 directly. req_valid never asserts for INV_LINE.

## Structure
- Shared package c1_pkg:
  - typedef enum logic [2:0] c1_cmd_t with the eight command codes;
  - typedef for the port state enum;
  - localparam C1_ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE.
- Sub-module c1_bus_drv: registered output-enable plus value for the command and data tri-states, owning the z release.

## Test plan
- READ8, tag_set=0x0000, offset=2; core returns 0x1234ABCD → bus shows command=7, data=0x00CD for exactly one cycle; req_addr=0x00002.
- WRITE8, offset=2, data=0x5555 → req_wdata=0x00000055, req_cmd=5; one response cycle with data left z.
- READ32, tag_set=0x0001, offset=0; rdata=0xDEADBEEF → two consecutive command=7 cycles with data 0xBEEF then 0xDEAD.
- req_ready held low 4 cycles → req_* stable throughout; no bus drive until a resp_valid arrives after the handshake.
- Reset pulsed while in WAIT → command and data go z in the same cycle; a later resp_valid produces no bus drive.
- INV_LINE with CACHE_C1_PORT_INV_EN undefined → no req_valid; command=7 appears 3 cycles after A1.

Source files
------------

// File: rtl/cache_c1_port_pkg.sv
// c1_pkg: shared types and sizes for the C1 slave port of the L1 cache.
// Holds the C1 command codes, the port FSM state encoding and the bus/address widths.
package c1_pkg;

    localparam int MEM_ADDR_SIZE     = 19;
    localparam int BUS_SIZE          = 16;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int C1_ADDR_W         = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

    typedef enum logic [2:0] {
        C1_NOP          = 3'd0,
        C1_READ8        = 3'd1,
        C1_READ16       = 3'd2,
        C1_READ32       = 3'd3,
        C1_INV_LINE     = 3'd4,
        C1_WRITE8       = 3'd5,
        C1_WRITE16      = 3'd6,
        C1_WRITE32_RESP = 3'd7
    } c1_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR2,
        ST_TURN_IN,
        ST_REQ,
        ST_WAIT,
        ST_RESP1,
        ST_RESP2,
        ST_TURN_OUT
    } c1_state_t;

    function automatic logic c1_is_read(c1_cmd_t c);
        return (c == C1_READ8) || (c == C1_READ16) || (c == C1_READ32);
    endfunction

endpackage

// File: rtl/cache_c1_port_bus_drv.sv
// c1_bus_drv: registered tri-state drivers for the C1 command and data lines.
// Enables and values are flopped so the bus is only ever driven from registered state;
// reset drops both enables asynchronously, releasing the bus at once.
module c1_bus_drv
    import c1_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_oe_d_i,
    input  logic                data_oe_d_i,
    input  logic [BUS_SIZE-1:0] data_d_i,
    inout  wire  [2:0]          command,
    inout  wire  [BUS_SIZE-1:0] data
);

    logic                cmd_oe_q;
    logic                data_oe_q;
    logic [BUS_SIZE-1:0] data_q;

    // Flop the output enables and the data value driven onto the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            data_q    <= '0;
        end else begin
            cmd_oe_q  <= cmd_oe_d_i;
            data_oe_q <= data_oe_d_i;
            data_q    <= data_d_i;
        end
    end

    assign command = cmd_oe_q  ? 3'd7   : 3'bzzz;
    assign data    = data_oe_q ? data_q : {BUS_SIZE{1'bz}};

endmodule

// File: rtl/cache_c1_port.sv
// cache_c1_port: C1 slave port in front of the L1 cache core.
// Decodes a two-cycle CPU transaction, issues one valid/ready request to the core,
// then drives the C1 response. One transaction outstanding at a time.
// Build option: CACHE_C1_PORT_INV_EN forwards INV_LINE to the core; when undefined,
// INV_LINE is answered locally without a core request.
module cache_c1_port
    import c1_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [C1_ADDR_W-1:0]     address,
    inout  wire  [BUS_SIZE-1:0]      data,
    inout  wire  [2:0]               command,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [2:0]               req_cmd,
    output logic [MEM_ADDR_SIZE-1:0] req_addr,
    output logic [2*BUS_SIZE-1:0]    req_wdata,
    input  logic                     resp_valid,
    input  logic [2*BUS_SIZE-1:0]    resp_rdata
);

    c1_state_t                    state_q;
    c1_cmd_t                      cmd_q;
    logic [C1_ADDR_W-1:0]         tag_q;
    logic [CACHE_OFFSET_SIZE-1:0] off_q;
    logic [BUS_SIZE-1:0]          wlo_q;
    logic [BUS_SIZE-1:0]          whi_q;
    logic [2*BUS_SIZE-1:0]        rdata_q;
    logic                         req_valid_q;

    logic [2:0]          cmd_in;
    logic                cmd_accept;
    logic                cmd_oe_d;
    logic                data_oe_d;
    logic [BUS_SIZE-1:0] data_d;

    assign cmd_in     = command;
    // Only codes 1..6 start a transaction; 0, 7 and unknown values fail the compare.
    assign cmd_accept = (cmd_in >= 3'd1) && (cmd_in <= 3'd6);

    // Port FSM: capture, request handshake, response capture and bus sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= C1_NOP;
            tag_q       <= '0;
            off_q       <= '0;
            wlo_q       <= '0;
            whi_q       <= '0;
            rdata_q     <= '0;
            req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        cmd_q   <= c1_cmd_t'(cmd_in);
                        tag_q   <= address;
                        wlo_q   <= data;
                        state_q <= ST_ADDR2;
                    end
                end
                ST_ADDR2: begin
                    off_q <= address[CACHE_OFFSET_SIZE-1:0];
                    // Code 7 is never accepted from the bus, so the upper word is
                    // normally zero; the path is kept for a 32-bit write command.
                    whi_q <= (cmd_q == C1_WRITE32_RESP) ? data : '0;
                    if (cmd_q == C1_WRITE8) begin
                        wlo_q[BUS_SIZE-1:8] <= '0;
                    end
                    state_q <= ST_TURN_IN;
                end
                ST_TURN_IN: begin
`ifdef CACHE_C1_PORT_INV_EN
                    state_q     <= ST_REQ;
                    req_valid_q <= 1'b1;
`else
                    if (cmd_q == C1_INV_LINE) begin
                        state_q <= ST_RESP1;
                    end else begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                    end
`endif
                end
                ST_REQ: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_valid) begin
                        rdata_q <= resp_rdata;
                        state_q <= ST_RESP1;
                    end
                end
                ST_RESP1:    state_q <= (cmd_q == C1_READ32) ? ST_RESP2 : ST_TURN_OUT;
                ST_RESP2:    state_q <= ST_TURN_OUT;
                ST_TURN_OUT: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Next bus drive derived from registered state only; flopped in c1_bus_drv,
    // so the bus follows the response states by one cycle.
    always_comb begin
        cmd_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        data_d    = rdata_q[BUS_SIZE-1:0];
        case (state_q)
            ST_RESP1: begin
                cmd_oe_d  = 1'b1;
                data_oe_d = c1_is_read(cmd_q);
                if (cmd_q == C1_READ8) begin
                    data_d = {8'h00, rdata_q[7:0]};
                end
            end
            ST_RESP2: begin
                cmd_oe_d  = 1'b1;
                data_oe_d = 1'b1;
                data_d    = rdata_q[2*BUS_SIZE-1:BUS_SIZE];
            end
            default: ;
        endcase
    end

    c1_bus_drv u_bus_drv (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_oe_d_i (cmd_oe_d),
        .data_oe_d_i(data_oe_d),
        .data_d_i   (data_d),
        .command    (command),
        .data       (data)
    );

    assign req_valid = req_valid_q;
    assign req_cmd   = cmd_q;
    assign req_addr  = {tag_q, off_q};
    assign req_wdata = {whi_q, wlo_q};

endmodule
